mod3_serial_tx: RTL and testbench
=================================

Name: mod3_serial_tx

Overview:
- Serial transmitter that produces bit streams divisible by 3. It is the generating end for the team's serial divide-by-3 checker FSM.
- Accepts a parallel WIDTH-bit word and shifts it out MSB-first, one bit per cycle.
- Appends two check bits c[1], c[0] so the transmitted (WIDTH+2)-bit value, V*4 + c, is always ≡ 0 mod 3.
- Sits between a parallel producer (valid/ready) and a serial sink with per-bit backpressure.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer offers data_in.
- data_in  in  WIDTH  word to transmit, unsigned.
- in_ready  out  1  block can accept a word.
- tx_ready  in  1  sink accepts tx_bit this cycle.
- tx_valid  out  1  tx_bit is valid.
- tx_bit  out  1  serial data, MSB-first, then c[1], then c[0].
- tx_last  out  1  marks the final bit (c[0]) of a frame.
- residue  out  2  running residue (0..2) of the bits already sent in the current frame. Debug/verification only.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, immediate, no clock needed):
  - state=IDLE; shift register, bit counter and residue cleared.
  - tx_valid=0, tx_bit=0, tx_last=0, residue=0.
  - in_ready=1, but no transfer can complete while rst_n=0.
- States: IDLE, DATA, CHK1, CHK0.
- IDLE:
  - in_ready=1, tx_valid=0.
  - On in_valid&in_ready at edge k: latch data_in, set count=WIDTH-1, residue=0, go to DATA.
  - First bit appears on tx_bit in the cycle after edge k (1-cycle latency).
- DATA:
  - tx_valid=1, tx_bit=shift[WIDTH-1].
  - On tx_valid&tx_ready: shift left, residue <= (2*residue + tx_bit) mod 3, count decrements.
  - When count==0 and the bit is accepted, compute c = (3 - residue_next) mod 3 ∈ {0,1,2} and go to CHK1.
- CHK1: tx_bit=c[1]; on acceptance go to CHK0.
- CHK0: tx_bit=c[0], tx_last=1; on acceptance go to IDLE.
- Backpressure: if tx_ready=0, tx_bit, tx_last, state, counter and residue all hold.
- in_ready=0 in DATA/CHK1/CHK0. in_valid is ignored outside IDLE.
- Frame spacing: minimum one IDLE cycle between frames. Frame length is WIDTH+2 accepted bits.
- Registered outputs: tx_bit, tx_valid, tx_last come from state/registers only, never combinationally from tx_ready or in_valid.
- Residue update is 2-bit modular arithmetic. The residue never takes value 3. The table is fixed:
  - r=0: b=0→0, b=1→1
  - r=1: b=0→2, b=1→0
  - r=2: b=0→1, b=1→2
- Boundary cases:
  - data_in=0 → c=00.
  - All-ones word → c follows the residue rule; no special case.
  - tx_ready held low indefinitely → stall with outputs stable.
  - rst_n asserted mid-frame → frame aborted, no tx_last, return to IDLE. Restart requires a new in_valid handshake.
  - Residue transmitted bit-by-bit stays ≤ 2 at all times.

Decomposition:
- Package mod3_pkg:
  - State encoding constants (IDLE, DATA, CHK1, CHK0; 2 bits).
  - Residue width constant (2).
  - Function mod3_next(r, b) implementing the table above.
  - Function mod3_check(r) returning (3-r) mod 3.
- Sub-module mod3_residue:
  - Clocked residue accumulator with clear and enable.
  - Reused by the checker side and the bench scoreboard.

Test Plan:
- WIDTH=8, data 0x05, tx_ready=1 → bits 0,0,0,0,0,1,0,1,0,1 on 10 consecutive cycles starting one cycle after accept. tx_last on the 10th bit. Value 21. residue ends at 0.
- data 0x07 → check bits 1,0 (value 30). data 0x06 → check bits 0,0 (value 24). data 0xFF → check bits 0,0 (value 1020).
- data 0x05 with tx_ready toggled 1,0,0,1,... pseudo-randomly → same 10-bit sequence. Outputs stable during every tx_ready=0 cycle. in_ready=0 throughout the frame.
- in_valid held high with a new word during a frame → new word ignored until IDLE. in_ready returns to 1 the cycle after the tx_last acceptance. Next frame starts after one idle cycle.
- rst_n pulled low after the 4th bit of 0xA5 → tx_valid, tx_last and residue drop to 0 immediately, no clock needed. After release, in_ready=1. A new frame of 0x01 outputs 0000_0001 then 1,0 (value 6).
- Random regression, 1000 words: feed the tx stream into the divide-by-3 checker FSM → every frame ends in residue state 0. Scoreboard c matches mod3_check of data_in mod 3.

Source files
------------

// File: rtl/mod3_pkg.sv
// Shared types and modulo-3 helpers for the serial divide-by-3 transmitter
// and its checker.
package mod3_pkg;

  localparam int unsigned RES_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CHK1 = 2'd2,
    ST_CHK0 = 2'd3
  } tx_state_e;

  // Residue after appending bit b to a stream whose residue is r: (2r + b) mod 3.
  function automatic logic [RES_W-1:0] mod3_next(input logic [RES_W-1:0] r,
                                                 input logic b);
    logic [RES_W-1:0] n;
    case ({r, b})
      3'b000:  n = 2'd0;
      3'b001:  n = 2'd1;
      3'b010:  n = 2'd2;
      3'b011:  n = 2'd0;
      3'b100:  n = 2'd1;
      3'b101:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Check value c such that (4r + c) mod 3 == 0, i.e. (3 - r) mod 3.
  function automatic logic [RES_W-1:0] mod3_check(input logic [RES_W-1:0] r);
    logic [RES_W-1:0] c;
    case (r)
      2'd1:    c = 2'd2;
      2'd2:    c = 2'd1;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mod3_residue.sv
// Clocked modulo-3 residue accumulator of a serial MSB-first bit stream,
// with synchronous clear (priority) and enable.
module mod3_residue
  import mod3_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [RES_W-1:0] residue,
  output logic [RES_W-1:0] residue_nxt
);

  logic [RES_W-1:0] res_q, res_d;

  always_comb begin
    residue_nxt = mod3_next(res_q, bit_in);
    res_d       = res_q;
    if (clr) begin
      res_d = '0;
    end else if (en) begin
      res_d = residue_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign residue = res_q;

endmodule

// File: rtl/mod3_serial_tx.sv
// Serial transmitter: shifts a WIDTH-bit word out MSB-first and appends two
// check bits so every (WIDTH+2)-bit frame is divisible by 3.
module mod3_serial_tx
  import mod3_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             in_ready,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic             tx_bit,
  output logic             tx_last,
  output logic [1:0]       residue
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_last_q, tx_last_d;
  logic             load, bit_acc;
  logic [RES_W-1:0] res_nxt;
  logic [RES_W-1:0] chk;

  assign load    = (state_q == ST_IDLE) && in_valid;
  assign bit_acc = tx_valid_q && tx_ready;

  mod3_residue u_res (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (load),
    .en          (bit_acc),
    .bit_in      (shift_q[WIDTH-1]),
    .residue     (residue),
    .residue_nxt (res_nxt)
  );

  // Check bits are loaded into the top of the shift register, so tx_bit is
  // always the register MSB in every state (and 0 in IDLE).
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    chk        = mod3_check(res_nxt);
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_DATA;
          shift_d    = data_in;
          cnt_d      = CNT_W'(WIDTH - 1);
          tx_valid_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_ready) begin
          if (cnt_q == '0) begin
            state_d                = ST_CHK1;
            shift_d                = '0;
            shift_d[WIDTH-1 -: 2]  = chk;
          end else begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_CHK1: begin
        if (tx_ready) begin
          state_d   = ST_CHK0;
          shift_d   = shift_q << 1;
          tx_last_d = 1'b1;
        end
      end
      ST_CHK0: begin
        if (tx_ready) begin
          state_d    = ST_IDLE;
          shift_d    = '0;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign tx_bit   = shift_q[WIDTH-1];

endmodule

// File: tb/tb_mod3_serial_tx.sv
// Bench for mod3_serial_tx: table vectors, hand-written corner sequences and a
// randomized regression against an arithmetic frame model.
module tb_mod3_serial_tx;

  localparam int FL = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic       in_ready;
  logic       tx_ready = 1'b0;
  logic       tx_valid, tx_bit, tx_last;
  logic [1:0] residue;
  logic [1:0] chk_res, chk_nxt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mod3_serial_tx #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .data_in  (data_in),
    .in_ready (in_ready),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_bit   (tx_bit),
    .tx_last  (tx_last),
    .residue  (residue)
  );

  mod3_residue u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (in_valid & in_ready),
    .en          (tx_valid & tx_ready),
    .bit_in      (tx_bit),
    .residue     (chk_res),
    .residue_nxt (chk_nxt)
  );

  typedef struct {
    logic [7:0] data;
    int         c;
    int         value;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sends one frame and checks every cycle against the arithmetic frame value
  // V*4 + (3 - V mod 3) mod 3. Residue expectation is the integer prefix mod 3.
  task automatic run_frame(input logic [7:0] d, input bit do_hs, input bit stall,
                           input bit hold, input logic [7:0] d2,
                           input int abort_at, output int got);
    int   fv, i, cyc;
    logic rdy;
    fv  = int'(d) * 4 + (3 - int'(d) % 3) % 3;
    got = 0;
    if (do_hs) begin
      @(negedge clk);
      check("in_ready_idle", int'(in_ready), 1);
      in_valid = 1'b1;
      data_in  = d;
    end
    i   = 0;
    cyc = 0;
    while (i < FL && cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_valid = hold;
      if (hold) data_in = d2;
      if (abort_at >= 0 && i == abort_at) return;
      check("tx_valid", int'(tx_valid), 1);
      check("in_ready_busy", int'(in_ready), 0);
      check("tx_bit", int'(tx_bit), (fv >> (FL - 1 - i)) & 1);
      check("tx_last", int'(tx_last), (i == FL - 1) ? 1 : 0);
      check("residue", int'(residue), (fv >> (FL - i)) % 3);
      if (!stall) rdy = 1'b1;
      else if (cyc == 1) rdy = 1'b0;
      else rdy = 1'($urandom_range(0, 1));
      tx_ready = rdy;
      if (rdy) begin
        got = got * 2 + int'(tx_bit);
        if (i == FL - 1) check("chk_final_res", int'(chk_nxt), 0);
        i++;
      end
    end
    check("frame_complete", i, FL);
    @(negedge clk);
    check("post_tx_valid", int'(tx_valid), 0);
    check("post_in_ready", int'(in_ready), 1);
    check("post_residue", int'(residue), 0);
    check("chk_residue", int'(chk_res), 0);
    check("frame_value", got, fv);
  endtask

  vec_t vecs[6];
  int   got;
  logic [7:0] rd;

  initial begin
    vecs[0] = '{8'h05, 1, 21};
    vecs[1] = '{8'h07, 2, 30};
    vecs[2] = '{8'h06, 0, 24};
    vecs[3] = '{8'hFF, 0, 1020};
    vecs[4] = '{8'h00, 0, 0};
    vecs[5] = '{8'h01, 2, 6};

    // Reset state, no clock edge yet
    #3;
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_tx_bit", int'(tx_bit), 0);
    check("rst_tx_last", int'(tx_last), 0);
    check("rst_residue", int'(residue), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      run_frame(vecs[k].data, 1'b1, 1'b0, 1'b0, 8'h00, -1, got);
      check("vec_value", got, vecs[k].value);
      check("vec_c", got % 4, vecs[k].c);
    end

    // Backpressure with 0x05
    run_frame(8'h05, 1'b1, 1'b1, 1'b0, 8'h00, -1, got);
    check("stall_value", got, 21);

    // in_valid held high with a new word during a frame
    run_frame(8'h07, 1'b1, 1'b0, 1'b1, 8'h06, -1, got);
    check("hold_first", got, 30);
    in_valid = 1'b1;
    data_in  = 8'h06;
    run_frame(8'h06, 1'b0, 1'b0, 1'b0, 8'h00, -1, got);
    check("hold_second", got, 24);

    // Asynchronous reset mid-frame after the 4th bit of 0xA5
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 4, got);
    #1 rst_n = 1'b0;
    #1;
    check("arst_tx_valid", int'(tx_valid), 0);
    check("arst_tx_last", int'(tx_last), 0);
    check("arst_residue", int'(residue), 0);
    check("arst_tx_bit", int'(tx_bit), 0);
    check("arst_in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    data_in  = 8'h33;
    @(posedge clk);
    #1;
    check("arst_no_xfer", int'(tx_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("arst_idle_valid", int'(tx_valid), 0);
    run_frame(8'h01, 1'b1, 1'b0, 1'b0, 8'h00, -1, got);
    check("arst_restart", got, 6);

    // Random regression
    for (int n = 0; n < 1000; n++) begin
      rd = 8'($urandom_range(0, 255));
      run_frame(rd, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'h00, -1, got);
      check("rand_div3", got % 3, 0);
      check("rand_c", got % 4, (3 - int'(rd) % 3) % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
